// File: rtl/dmem_mmio.sv
// dmem_mmio -- data-side responder for the single-cycle MIPS core.
//
// Serves the core's data-memory port. It contains a word-addressed RAM and a
// small register window at MMIO_BASE. The window holds an LED register, a
// free-running cycle counter and an optional countdown timer with interrupt.
// Reads are combinational. Writes and counter updates occur on the rising
// clock edge.
//
// Build option: define DMEM_TIMER_EN to include the timer. When it is left
// undefined there are no timer flops, the timer offsets read 0 and irq is
// tied to 0.
//
// Ports:
//   clock  in   1   rising-edge clock
//   reset  in   1   asynchronous, active-low reset (RAM is not reset)
//   we     in   1   write enable from the core
//   ra     in  32   byte address; bits [1:0] are ignored (word access only)
//   wd     in  32   write data
//   rd     out 32   read data, combinational, pre-edge register state
//   leds   out  8   LED register
//   irq    out  1   timer interrupt, TFLAG & TIE
//
// Timer FSM (state | meaning):
//   IDLE | TEN=0, TCOUNT holds its value
//   RUN  | TEN=1, TCOUNT counts down, expiry sets TFLAG
module dmem_mmio #(
  parameter int unsigned RAM_WORDS = 64,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] ra,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic [7:0]  leds,
  output logic        irq
);

  localparam int unsigned AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

  // Register offsets as word indices (ra[15:2]).
  localparam logic [13:0] OFF_LED   = 14'h0000;
  localparam logic [13:0] OFF_CYCLE = 14'h0001;

  logic          is_mmio;
  logic [AW-1:0] ram_idx;
  logic [13:0]   word_off;
  logic          mmio_we;
  logic          unused_byte_lane;
  logic [31:0]   timer_rd;

  assign is_mmio          = (ra[31:16] == MMIO_BASE[31:16]);
  assign ram_idx          = ra[AW+1:2];
  assign word_off         = ra[15:2];
  assign mmio_we          = we & is_mmio;
  assign unused_byte_lane = ^ra[1:0];

  // RAM: no reset, so its contents survive a core reset.
  logic [31:0] ram_q [RAM_WORDS];

  always_ff @(posedge clock) begin
    if (we && !is_mmio) ram_q[ram_idx] <= wd;
  end

  // LED register and cycle counter.
  logic [7:0]  led_q, led_d;
  logic [31:0] cycle_q, cycle_d;

  always_comb begin
    led_d = led_q;
    if (mmio_we && (word_off == OFF_LED)) led_d = wd[7:0];
  end

  assign cycle_d = cycle_q + 32'd1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      led_q   <= 8'd0;
      cycle_q <= 32'd0;
    end else begin
      led_q   <= led_d;
      cycle_q <= cycle_d;
    end
  end

  assign leds = led_q;

`ifdef DMEM_TIMER_EN
  localparam logic [13:0] OFF_TCTRL  = 14'h0002;
  localparam logic [13:0] OFF_TLOAD  = 14'h0003;
  localparam logic [13:0] OFF_TCOUNT = 14'h0004;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // TEN is the FSM state itself, so it has no separate flop.
  logic [0:0]  state_q, state_d;
  logic        treload_q, treload_d;
  logic        tie_q, tie_d;
  logic        tflag_q, tflag_d;
  logic [31:0] tload_q, tload_d;
  logic [31:0] tcount_q, tcount_d;
  logic        wr_tctrl, wr_tload, expire;

  assign wr_tctrl = mmio_we && (word_off == OFF_TCTRL);
  assign wr_tload = mmio_we && (word_off == OFF_TLOAD);
  assign expire   = (state_q == ST_RUN) && (tcount_q == 32'd1);

  always_comb begin
    state_d   = state_q;
    treload_d = treload_q;
    tie_d     = tie_q;
    tflag_d   = tflag_q;
    tload_d   = tload_q;
    tcount_d  = tcount_q;

    if (wr_tload) tload_d = wd;

    if (wr_tctrl) begin
      treload_d = wd[1];
      tie_d     = wd[2];
      if (wd[3]) tflag_d = 1'b0;
    end
    // The set is applied after the clear so that an expiry wins over a
    // W1C write in the same cycle.
    if (expire) tflag_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (wr_tctrl && wd[0]) begin
          tcount_d = tload_q;
          if (tload_q != 32'd0) state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // A TCTRL write takes priority over the count: bit0=1 restarts the
        // timer and bit0=0 stops it with TCOUNT frozen.
        if (wr_tctrl) begin
          if (wd[0]) begin
            tcount_d = tload_q;
            if (tload_q == 32'd0) state_d = ST_IDLE;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (expire) begin
          if (treload_q && (tload_q != 32'd0)) begin
            tcount_d = tload_q;
          end else begin
            tcount_d = 32'd0;
            state_d  = ST_IDLE;
          end
        end else if (tcount_q == 32'd0) begin
          state_d = ST_IDLE;
        end else begin
          tcount_d = tcount_q - 32'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      treload_q <= 1'b0;
      tie_q     <= 1'b0;
      tflag_q   <= 1'b0;
      tload_q   <= 32'd0;
      tcount_q  <= 32'd0;
    end else begin
      state_q   <= state_d;
      treload_q <= treload_d;
      tie_q     <= tie_d;
      tflag_q   <= tflag_d;
      tload_q   <= tload_d;
      tcount_q  <= tcount_d;
    end
  end

  always_comb begin
    timer_rd = 32'd0;
    case (word_off)
      OFF_TCTRL:  timer_rd = {28'd0, tflag_q, tie_q, treload_q, (state_q == ST_RUN)};
      OFF_TLOAD:  timer_rd = tload_q;
      OFF_TCOUNT: timer_rd = tcount_q;
      default:    timer_rd = 32'd0;
    endcase
  end

  assign irq = tflag_q & tie_q;
`else
  assign timer_rd = 32'd0;
  assign irq      = 1'b0;
`endif

  // Read mux. Any unused offset in the window falls through to timer_rd,
  // which is 0 everywhere outside the timer registers.
  always_comb begin
    rd = ram_q[ram_idx];
    if (is_mmio) begin
      case (word_off)
        OFF_LED:   rd = {24'd0, led_q};
        OFF_CYCLE: rd = cycle_q;
        default:   rd = timer_rd;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_mmio.sv
module tb_dmem_mmio;

  localparam int unsigned RAM_WORDS = 64;
  localparam logic [31:0] A_LED    = 32'hFFFF_0000;
  localparam logic [31:0] A_CYCLE  = 32'hFFFF_0004;
  localparam logic [31:0] A_TCTRL  = 32'hFFFF_0008;
  localparam logic [31:0] A_TLOAD  = 32'hFFFF_000C;
  localparam logic [31:0] A_TCOUNT = 32'hFFFF_0010;
  localparam int NV = 17;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        we    = 1'b0;
  logic [31:0] ra    = 32'd0;
  logic [31:0] wd    = 32'd0;
  logic [31:0] rd;
  logic [7:0]  leds;
  logic        irq;

  int n_checks = 0;
  int n_errors = 0;

  dmem_mmio #(
    .RAM_WORDS(RAM_WORDS),
    .MMIO_BASE(32'hFFFF_0000)
  ) dut (
    .clock(clock),
    .reset(reset),
    .we   (we),
    .ra   (ra),
    .wd   (wd),
    .rd   (rd),
    .leds (leds),
    .irq  (irq)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic [7:0]  exp_leds;
  } vec_t;

  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    we = 1'b1;
    ra = a;
    wd = d;
    step();
    we = 1'b0;
  endtask

  task automatic rchk(input string name, input logic [31:0] a, input logic [31:0] exp);
    we = 1'b0;
    ra = a;
    #1;
    check(name, rd, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] c0, c1;

    //               we    addr          wdata         chk   exp_rd        leds
    vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0,        8'h00};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b1, 32'hDEAD_BEEF, 8'h00};
    vecs[2]  = '{1'b0, 32'h0000_0110, 32'h0,         1'b1, 32'hDEAD_BEEF, 8'h00};
    vecs[3]  = '{1'b0, 32'h0000_0013, 32'h0,         1'b1, 32'hDEAD_BEEF, 8'h00};
    vecs[4]  = '{1'b1, 32'h0000_0010, 32'h0000_0055, 1'b1, 32'hDEAD_BEEF, 8'h00};
    vecs[5]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b1, 32'h0000_0055, 8'h00};
    vecs[6]  = '{1'b1, A_LED,         32'h0000_01A5, 1'b0, 32'h0,        8'hA5};
    vecs[7]  = '{1'b0, A_LED,         32'h0,         1'b1, 32'h0000_00A5, 8'hA5};
    vecs[8]  = '{1'b0, 32'hFFFF_0020, 32'h0,         1'b1, 32'h0000_0000, 8'hA5};
    vecs[9]  = '{1'b0, 32'hFFFF_0003, 32'h0,         1'b1, 32'h0000_00A5, 8'hA5};
    vecs[10] = '{1'b1, 32'h0000_0020, 32'h1111_1111, 1'b0, 32'h0,        8'hA5};
    vecs[11] = '{1'b1, 32'hFFFF_0020, 32'h2222_2222, 1'b0, 32'h0,        8'hA5};
    vecs[12] = '{1'b0, 32'h0000_0020, 32'h0,         1'b1, 32'h1111_1111, 8'hA5};
    vecs[13] = '{1'b1, 32'hFFFE_0000, 32'hCAFE_0001, 1'b0, 32'h0,        8'hA5};
    vecs[14] = '{1'b0, 32'h0000_0000, 32'h0,         1'b1, 32'hCAFE_0001, 8'hA5};
    vecs[15] = '{1'b0, A_LED,         32'h0,         1'b1, 32'h0000_00A5, 8'hA5};
    vecs[16] = '{1'b1, A_LED,         32'h0000_FF3C, 1'b0, 32'h0,        8'h3C};

    // Values while reset is held.
    #1;
    check("reset leds", {24'd0, leds}, 32'd0);
    check("reset irq", {31'd0, irq}, 32'd0);
    rchk("reset led reg", A_LED, 32'd0);
    rchk("reset cycle", A_CYCLE, 32'd0);
    step();
    rchk("reset cycle held", A_CYCLE, 32'd0);
    #10;
    reset = 1'b1;
    step();

    for (int i = 0; i < NV; i++) begin
      we = vecs[i].we;
      ra = vecs[i].addr;
      wd = vecs[i].wdata;
      #1;
      if (vecs[i].chk_rd) check($sformatf("vec%0d rd", i), rd, vecs[i].exp_rd);
      step();
      we = 1'b0;
      check($sformatf("vec%0d leds", i), {24'd0, leds}, {24'd0, vecs[i].exp_leds});
    end

    // Cycle counter: difference between two reads, then a forced wrap.
    we = 1'b0;
    ra = A_CYCLE;
    #1;
    c0 = rd;
    repeat (7) @(posedge clock);
    #1;
    c1 = rd;
    check("cycle delta", c1 - c0, 32'd7);

    force dut.cycle_d = 32'hFFFF_FFFF;
    step();
    release dut.cycle_d;
    rchk("cycle at max", A_CYCLE, 32'hFFFF_FFFF);
    step();
    rchk("cycle wrap", A_CYCLE, 32'd0);
    wr(A_CYCLE, 32'h0000_1000);
    rchk("cycle write ignored", A_CYCLE, 32'd1);

`ifdef DMEM_TIMER_EN
    // Enabling with TLOAD=0 leaves the timer idle.
    wr(A_TCTRL, 32'h1);
    rchk("tload0 ctrl", A_TCTRL, 32'h0);
    rchk("tload0 count", A_TCOUNT, 32'h0);

    // One-shot, TLOAD=3, TIE set.
    wr(A_TLOAD, 32'd3);
    rchk("A tload", A_TLOAD, 32'd3);
    wr(A_TCTRL, 32'h5);
    rchk("A count 3", A_TCOUNT, 32'd3);
    rchk("A ctrl run", A_TCTRL, 32'h5);
    step();
    rchk("A count 2", A_TCOUNT, 32'd2);
    step();
    rchk("A count 1", A_TCOUNT, 32'd1);
    check("A irq before expiry", {31'd0, irq}, 32'd0);
    step();
    rchk("A count 0", A_TCOUNT, 32'd0);
    rchk("A ctrl expired", A_TCTRL, 32'hC);
    check("A irq set", {31'd0, irq}, 32'd1);
    step();
    rchk("A count stays 0", A_TCOUNT, 32'd0);
    wr(A_TCTRL, 32'hC);
    rchk("A ctrl after w1c", A_TCTRL, 32'h4);
    check("A irq cleared", {31'd0, irq}, 32'd0);

    // Auto-reload, TLOAD=2.
    wr(A_TLOAD, 32'd2);
    wr(A_TCTRL, 32'h7);
    rchk("B ctrl run", A_TCTRL, 32'h7);
    rchk("B count 2", A_TCOUNT, 32'd2);
    step();
    rchk("B count 1", A_TCOUNT, 32'd1);
    step();
    rchk("B reload", A_TCOUNT, 32'd2);
    rchk("B ctrl flag", A_TCTRL, 32'hF);
    check("B irq set", {31'd0, irq}, 32'd1);
    step();
    rchk("B count 1 again", A_TCOUNT, 32'd1);
    wr(A_TCTRL, 32'hF);
    rchk("B w1c on expiry", A_TCTRL, 32'hF);
    rchk("B restart count", A_TCOUNT, 32'd2);
    step();
    rchk("B period count 1", A_TCOUNT, 32'd1);
    step();
    rchk("B period reload", A_TCOUNT, 32'd2);
    step();
    check("B irq before reset", {31'd0, irq}, 32'd1);
    reset = 1'b0;
    #1;
    check("B irq in reset", {31'd0, irq}, 32'd0);
    rchk("B count in reset", A_TCOUNT, 32'd0);
    rchk("B ctrl in reset", A_TCTRL, 32'd0);
    check("B leds in reset", {24'd0, leds}, 32'd0);
    reset = 1'b1;
    step();
`else
    wr(A_TLOAD, 32'h0000_1234);
    wr(A_TCTRL, 32'hF);
    rchk("notimer ctrl", A_TCTRL, 32'd0);
    rchk("notimer tload", A_TLOAD, 32'd0);
    rchk("notimer tcount", A_TCOUNT, 32'd0);
    repeat (3) step();
    check("notimer irq", {31'd0, irq}, 32'd0);
    reset = 1'b0;
    #1;
    check("notimer leds in reset", {24'd0, leds}, 32'd0);
    reset = 1'b1;
    step();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dmem_mmio.md
# dmem_mmio

Data-side responder for the single-cycle MIPS core. It answers the core's data-memory port (`we`, address, write data, read data) with a word-addressed RAM plus a small memory-mapped register window: an LED register, a free-running cycle counter and an optional countdown timer with interrupt. Reads are combinational, as the single-cycle datapath requires; all writes and counter updates are synchronous.

## Interface
- `RAM_WORDS`, 64, RAM depth in 32-bit words (power of two)
- `MMIO_BASE`, 32'hFFFF_0000, base byte address of the register window (64 KiB aligned)

- `clock`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `we`  in  1  write enable from core (`dmem_we`)
- `ra`  in  32  byte address from core (`alu_out`)
- `wd`  in  32  write data from core (`dmem_wd`)
- `rd`  out  32  read data to core, combinational
- `leds`  out  8  LED register contents
- `irq`  out  1  timer interrupt, `TFLAG & TIE`

## Operation
- Decode: `ra[31:16] == MMIO_BASE[31:16]` selects MMIO, else RAM. `ra[1:0]` ignored in both regions; word access only.
- RAM: index `ra[log2(RAM_WORDS)+1:2]`, so addresses wrap modulo RAM size. RAM is not reset; read of an unwritten word is X.
- MMIO offsets (`ra[15:0]`):
  - 0x00 LED: RW, bits[7:0] drive `leds`, upper bits read 0.
  - 0x04 CYCLE: RO, 32-bit counter, +1 every cycle, wraps 0xFFFF_FFFF→0. Writes ignored.
  - 0x08 TCTRL: bit0 TEN, bit1 TRELOAD, bit2 TIE (all RW); bit3 TFLAG (read; write 1 clears, write 0 no effect). Other bits read 0.
  - 0x0C TLOAD: RW reload value.
  - 0x10 TCOUNT: RO current count.
  - Any other offset reads 0; writes ignored.
- Timer FSM, states IDLE (TEN=0) and RUN (TEN=1):
  - IDLE→RUN: write TCTRL with bit0=1. TCOUNT←TLOAD on that edge. If TLOAD==0, TEN stays 0 and state stays IDLE.
  - RUN: TCOUNT decrements each cycle. On the edge where TCOUNT==1, TCOUNT←0 and TFLAG←1. Then if TRELOAD, TCOUNT←TLOAD and stay in RUN; else TEN←0 → IDLE.
  - RUN→IDLE: write TCTRL bit0=0. TCOUNT holds its value.
  - A write to TLOAD while in RUN does not disturb TCOUNT; the new value applies at the next reload.
- Simultaneous events:
  - Expiry in the same cycle as a TFLAG W1C write: set wins, TFLAG=1.
  - A TCTRL write in RUN with bit0=1 reloads TCOUNT from TLOAD (restart).

## Timing
- `rd` valid combinationally in the same cycle as `ra`. It reflects register state before the current edge: a CYCLE read returns the pre-increment value, and a same-address write is not forwarded.
- Writes (RAM and registers) take effect at the rising edge when `we`=1.
- `irq` is registered-derived: it asserts the cycle after the expiry edge and deasserts the cycle after the W1C edge or TIE clear.
- Reset (`reset`=0, async): LED, CYCLE, TCTRL, TLOAD and TCOUNT go to 0, so `leds`=0 and `irq`=0 immediately. Timer goes to IDLE mid-count. RAM is untouched.
- Latency from TCTRL enable with TLOAD=N to TFLAG set: N edges after the enabling edge.

## Configuration
- `DMEM_TIMER_EN` defined: timer registers and FSM present as above.
- Undefined: offsets 0x08–0x10 read 0, writes ignored, `irq` tied 0, no timer flops. LED, CYCLE and RAM are unchanged.

## Test plan
- Reset then RAM write 0xDEADBEEF at 0x10, read 0x10 → 0xDEADBEEF; read 0x10+4·RAM_WORDS → 0xDEADBEEF (wrap).
- Write 0x1A5 to LED → `leds`=0xA5, LED reads 0x0000_00A5; read offset 0x20 → 0.
- Read CYCLE at two points k cycles apart → difference k; force CYCLE=0xFFFF_FFFF → next read 0.
- TLOAD=3, TCTRL=0x5 (TEN, TIE) → TCOUNT 3,2,1,0, TFLAG set on the 3rd edge, `irq`=1, TEN=0; write TCTRL bit3=1 → `irq`=0.
- TLOAD=2, TRELOAD=1 → TFLAG set every 2 cycles. A W1C write on an expiry cycle leaves TFLAG=1. Assert `reset` mid-count → `irq`=0 and TCOUNT=0 immediately.
- Build without `DMEM_TIMER_EN` → TCTRL/TLOAD/TCOUNT read 0 after writes, `irq` stays 0.
